// File: rtl/sim_result_reader.sv
// Snoops DM stores for the end-of-simulation marker, then reads the result words back
// through the DM SRAM port and streams them out. Optional RESULT_CYCLE_EN appends the
// 64-bit cycle count as two extra words.
module sim_result_reader #(
  parameter int unsigned       ADDR_W       = 14,
  parameter logic [ADDR_W-1:0] TEST_START   = 14'h2000,
  parameter logic [ADDR_W-1:0] SIM_END_ADDR = 14'h3fff,
  parameter logic [31:0]       END_CODE     = 32'hFFFF_FFFF,
  parameter int unsigned       MAX_WORDS    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snoop_we_i,
  input  logic [ADDR_W-1:0] snoop_addr_i,
  input  logic [31:0]       snoop_wdata_i,
  input  logic [6:0]        cfg_num_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_ceb_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_data_o,
  output logic              out_last_o,
  output logic              halted_o,
  output logic              done_o
);

  typedef enum logic [2:0] {RUN, REQ, RD, CAP, SEND, CYC_LO, CYC_HI, DONE} state_e;

  localparam logic [6:0] MAX_N = 7'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [6:0]  n_q, n_d;
  logic [6:0]  idx_q, idx_d;
  logic        halted_q, halted_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic [31:0] data_q, data_d;
  logic        halt_hit;
  logic        send_fire;
  logic [6:0]  idx_inc;
`ifdef RESULT_CYCLE_EN
  logic [63:0] cyc_q, cyc_d;
`endif

  assign halt_hit  = snoop_we_i && (snoop_addr_i == SIM_END_ADDR) && (snoop_wdata_i == END_CODE);
  assign send_fire = valid_q && out_ready_i;
  assign idx_inc   = idx_q + 7'd1;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    halted_d   = halted_q;
    valid_d    = valid_q;
    last_d     = last_q;
    data_d     = data_q;
    done_d     = 1'b0;
    mem_req_o  = 1'b0;
    mem_ceb_o  = 1'b1;
    mem_addr_o = '0;
`ifdef RESULT_CYCLE_EN
    cyc_d      = cyc_q;
`endif
    unique case (state_q)
      RUN: begin
        if (halt_hit) begin
          n_d      = (cfg_num_i > MAX_N) ? MAX_N : cfg_num_i;
          idx_d    = '0;
          halted_d = 1'b1;
          if (n_d == '0) begin
`ifdef RESULT_CYCLE_EN
            state_d = CYC_LO;
            data_d  = cyc_q[31:0];
            valid_d = 1'b1;
            last_d  = 1'b0;
`else
            state_d = DONE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = REQ;
          end
        end else begin
`ifdef RESULT_CYCLE_EN
          cyc_d = cyc_q + 64'd1;
`endif
        end
      end
      REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = RD;
      end
      RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = TEST_START + ADDR_W'(idx_q);
        if (mem_gnt_i) begin
          mem_ceb_o = 1'b0;
          state_d   = CAP;
        end
      end
      CAP: begin
        mem_req_o = 1'b1;
        data_d    = mem_rdata_i;
        valid_d   = 1'b1;
`ifdef RESULT_CYCLE_EN
        last_d    = 1'b0;
`else
        last_d    = (idx_inc == n_q);
`endif
        state_d   = SEND;
      end
      SEND: begin
        mem_req_o = 1'b1;
        if (send_fire) begin
          idx_d   = idx_inc;
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (idx_inc < n_q) begin
            state_d = RD;
          end else begin
`ifdef RESULT_CYCLE_EN
            state_d = CYC_LO;
            data_d  = cyc_q[31:0];
            valid_d = 1'b1;
`else
            state_d = DONE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef RESULT_CYCLE_EN
      CYC_LO: begin
        if (send_fire) begin
          data_d  = cyc_q[63:32];
          last_d  = 1'b1;
          state_d = CYC_HI;
        end
      end
      CYC_HI: begin
        if (send_fire) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
`endif
      // DONE is terminal until reset; later markers are deliberately ignored.
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      n_q      <= '0;
      idx_q    <= '0;
      halted_q <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
`ifdef RESULT_CYCLE_EN
      cyc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      halted_q <= halted_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      data_q   <= data_d;
`ifdef RESULT_CYCLE_EN
      cyc_q    <= cyc_d;
`endif
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign halted_o    = halted_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_sim_result_reader.sv
// Directed bench for sim_result_reader with a behavioural DM SRAM that logs every read.
module tb_sim_result_reader;

  localparam logic [31:0] END_CODE = 32'hFFFF_FFFF;
`ifdef RESULT_CYCLE_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snoop_we = 1'b0;
  logic [13:0] snoop_addr = '0;
  logic [31:0] snoop_wdata = '0;
  logic [6:0]  cfg_num = '0;
  logic        mem_req;
  logic        mem_gnt = 1'b1;
  logic        mem_ceb;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        halted;
  logic        done;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] mem [0:16383];
  logic [13:0] rd_log [$];

  logic [31:0] got_d [0:127];
  logic        got_l [0:127];
  int          unstable;

  always #5 clk = ~clk;

  sim_result_reader dut (
    .clk          (clk),
    .rst          (rst),
    .snoop_we_i   (snoop_we),
    .snoop_addr_i (snoop_addr),
    .snoop_wdata_i(snoop_wdata),
    .cfg_num_i    (cfg_num),
    .mem_req_o    (mem_req),
    .mem_gnt_i    (mem_gnt),
    .mem_ceb_o    (mem_ceb),
    .mem_addr_o   (mem_addr),
    .mem_rdata_i  (mem_rdata),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_last_o   (out_last),
    .halted_o     (halted),
    .done_o       (done)
  );

  // SRAM: data appears the cycle after a read with ceb low.
  always @(posedge clk) begin
    if (!mem_ceb) begin
      mem_rdata <= mem[mem_addr];
      rd_log.push_back(mem_addr);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One-cycle store; returns at the negedge following the store edge.
  task automatic store(input logic [13:0] addr, input logic [31:0] data);
    snoop_we    = 1'b1;
    snoop_addr  = addr;
    snoop_wdata = data;
    @(negedge clk);
    snoop_we    = 1'b0;
  endtask

  // Collects nw words; stall=1 makes ready high one cycle in three; grant drops
  // for five cycles starting at loop cycle drop_at (negative = never).
  task automatic recv(input int nw, input bit stall, input int drop_at, output int got);
    int cyc = 0;
    int k = 0;
    bit holding = 1'b0;
    logic [31:0] held_d = '0;
    logic held_l = 1'b0;
    unstable = 0;
    while (k < nw && cyc < 2000) begin
      if (holding && (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l))
        unstable++;
      out_ready = stall ? ((cyc % 3) == 0) : 1'b1;
      mem_gnt   = !(drop_at >= 0 && cyc >= drop_at && cyc < drop_at + 5);
      holding   = 1'b0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          got_d[k] = out_data;
          got_l[k] = out_last;
          k++;
        end else begin
          holding = 1'b1;
          held_d  = out_data;
          held_l  = out_last;
        end
      end
      @(negedge clk);
      cyc++;
    end
    mem_gnt = 1'b1;
    got = k;
  endtask

  initial begin
    int base;
    int lat;
    int got;
    int lasts;
    int errs;
    bit seen;

    do_reset();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_ceb", mem_ceb, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_halted", halted, 0);
    check("rst_done", done, 0);

    // Marker filtering, then a three-word stream with ready tied high.
    mem[14'h2000] = 32'd11;
    mem[14'h2001] = 32'd22;
    mem[14'h2002] = 32'd33;
    cfg_num = 7'd3;
    store(14'h3fff, 32'h1234);
    check("ignore_wrong_data", halted, 0);
    store(14'h3ffe, END_CODE);
    check("ignore_wrong_addr", halted, 0);
    base = rd_log.size();
    store(14'h3fff, END_CODE);
    check("halted_rise", halted, 1);
    check("req_after_halt", mem_req, 1);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("first_valid_latency", lat, 4);
    recv(3 + EXTRA, 1'b0, -1, got);
    check("basic_count", got, 3 + EXTRA);
    check("basic_w0", got_d[0], 11);
    check("basic_w1", got_d[1], 22);
    check("basic_w2", got_d[2], 33);
    lasts = 0;
    for (int j = 0; j < 3 + EXTRA; j++) lasts += int'(got_l[j]);
    check("basic_last_count", lasts, 1);
    check("basic_last_pos", got_l[2 + EXTRA], 1);
    check("basic_done_pulse", done, 1);
    check("basic_reads", rd_log.size() - base, 3);
    @(negedge clk);
    check("basic_done_drop", done, 0);
    check("basic_req_drop", mem_req, 0);
    check("basic_halted_sticky", halted, 1);
    store(14'h3fff, END_CODE);
    seen = 1'b0;
    repeat (6) begin
      if (out_valid !== 1'b0 || done !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    check("rehalt_ignored", seen, 0);

    // Same stream with 1-in-3 ready and a five-cycle grant gap.
    do_reset();
    check("rst2_halted", halted, 0);
    base = rd_log.size();
    store(14'h3fff, END_CODE);
    recv(3 + EXTRA, 1'b1, 4, got);
    check("stall_count", got, 3 + EXTRA);
    check("stall_w0", got_d[0], 11);
    check("stall_w1", got_d[1], 22);
    check("stall_w2", got_d[2], 33);
    check("stall_stable", unstable, 0);
    check("stall_reads", rd_log.size() - base, 3);
    check("stall_last_pos", got_l[2 + EXTRA], 1);

    // cfg_num above the cap: exactly 64 words from 'h2000..'h203f.
    do_reset();
    for (int j = 0; j < 65; j++) mem[14'h2000 + 14'(j)] = 32'h5000_0000 + 32'(j * 3);
    cfg_num = 7'd100;
    base = rd_log.size();
    store(14'h3fff, END_CODE);
    recv(64 + EXTRA, 1'b0, -1, got);
    check("cap_count", got, 64 + EXTRA);
    errs = 0;
    lasts = 0;
    for (int j = 0; j < 64; j++) if (got_d[j] !== 32'h5000_0000 + 32'(j * 3)) errs++;
    for (int j = 0; j < 64 + EXTRA; j++) lasts += int'(got_l[j]);
    check("cap_data", errs, 0);
    check("cap_last_count", lasts, 1);
    check("cap_last_pos", got_l[63 + EXTRA], 1);
    check("cap_reads", rd_log.size() - base, 64);
    errs = 0;
    for (int j = 0; j < 64 && base + j < rd_log.size(); j++)
      if (rd_log[base + j] !== 14'h2000 + 14'(j)) errs++;
    check("cap_addr_seq", errs, 0);
    check("cap_done", done, 1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check("cap_no_extra", seen, 0);

    // cfg_num = 0.
    do_reset();
    cfg_num = 7'd0;
    base = rd_log.size();
`ifdef RESULT_CYCLE_EN
    // Counter counts posedges since reset release; 1000 edges before the halt edge.
    repeat (1000) @(negedge clk);
    store(14'h3fff, END_CODE);
    recv(2, 1'b0, -1, got);
    check("cyc_count", got, 2);
    check("cyc_lo", got_d[0], 32'd1000);
    check("cyc_hi", got_d[1], 32'd0);
    check("cyc_lo_last", got_l[0], 0);
    check("cyc_hi_last", got_l[1], 1);
    check("cyc_done", done, 1);
`else
    store(14'h3fff, END_CODE);
    check("zero_done", done, 1);
    check("zero_valid", out_valid, 0);
    check("zero_req", mem_req, 0);
    @(negedge clk);
    check("zero_done_drop", done, 0);
`endif
    check("zero_reads", rd_log.size() - base, 0);

    // Reset in SEND, then a fresh run from 'h2000.
    do_reset();
    cfg_num = 7'd3;
    out_ready = 1'b0;
    store(14'h3fff, END_CODE);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("abort_reach_send", out_valid, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_mem_req", mem_req, 0);
    check("abort_mem_ceb", mem_ceb, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_halted", halted, 0);
    check("abort_done", done, 0);
    do_reset();
    seen = 1'b0;
    repeat (3) begin
      if (done !== 1'b0 || out_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_quiet", seen, 0);
    mem[14'h2000] = 32'hCAFE_0001;
    cfg_num = 7'd1;
    base = rd_log.size();
    store(14'h3fff, END_CODE);
    recv(1 + EXTRA, 1'b0, -1, got);
    check("restart_count", got, 1 + EXTRA);
    check("restart_data", got_d[0], 32'hCAFE_0001);
    check("restart_reads", rd_log.size() - base, 1);
    check("restart_addr", (rd_log.size() > base) ? rd_log[base] : 14'h3fff, 14'h2000);
    check("restart_done", done, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sim_result_reader.md
# sim_result_reader

Hardware end of the simulation-result protocol: the CPU program writes results into DM starting at word `TEST_START` and then writes `END_CODE` to word `SIM_END_ADDR`. This block snoops the DM write port for that end marker, takes over the DM SRAM read port, reads the result words back in order and streams them out on a valid/ready interface. It lets results leave the chip (or FPGA) without backdoor memory access, and sits in `top` beside DM1 with a port arbiter in front of the SRAM.

## Interface
- `ADDR_W`, 14, DM word-address width (16384 words)
- `TEST_START`, 14'h2000, word address of the first result
- `SIM_END_ADDR`, 14'h3fff, word address of the end marker
- `END_CODE`, 32'hFFFF_FFFF, end-marker value
- `MAX_WORDS`, 64, cap on result words read

- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `snoop_we`  in  1  DM write strobe from the CPU, one cycle per store
- `snoop_addr`  in  ADDR_W  DM word address of the store
- `snoop_wdata`  in  32  full-word store data
- `cfg_num`  in  7  number of result words; sampled at halt detection
- `mem_req`  out  1  request for the DM port
- `mem_gnt`  in  1  DM port granted to this block
- `mem_ceb`  out  1  active-low SRAM chip enable for reads
- `mem_addr`  out  ADDR_W  SRAM word read address
- `mem_rdata`  in  32  SRAM read data, valid the cycle after `mem_ceb`=0
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  downstream accepts the word
- `out_data`  out  32  stream word
- `out_last`  out  1  marks the final stream word
- `halted`  out  1  end marker has been seen; sticky until reset
- `done`  out  1  one-cycle pulse after the last word is accepted

## Operation
- States: RUN, REQ, RD, CAP, SEND, CYC_LO, CYC_HI, DONE.
- RUN: halt is detected when `snoop_we`=1, `snoop_addr`=SIM_END_ADDR and `snoop_wdata`=END_CODE, all in the same cycle. A matching address with other data, or END_CODE to another address, is ignored.
- On halt: latch `n = min(cfg_num, MAX_WORDS)`, clear index `i`, set `halted`, freeze the cycle counter, then go to REQ. If `n`=0, skip to CYC_LO when RESULT_CYCLE_EN is defined, otherwise go to DONE.
- REQ: `mem_req`=1. Wait for `mem_gnt`, then go to RD.
- RD: `mem_ceb`=0, `mem_addr`=TEST_START+`i`, then go to CAP. If `mem_gnt` is low here, stay in RD with `mem_ceb`=1 until it returns.
- CAP: register `mem_rdata` into `out_data`, set `out_valid`, go to SEND.
- SEND: hold `out_data` stable until `out_valid && out_ready`. Then increment `i`; go to RD if `i<n`, otherwise drop `mem_req` and go to CYC_LO (or DONE).
- `mem_req` stays high from REQ until the last word is accepted.
- CYC_LO/CYC_HI: send the low and then the high 32 bits of the frozen cycle count, each with the same valid/ready hold rule.
- `out_last`=1 on the final word only.
- DONE: pulse `done` for one cycle, then stay idle. Further snoop matches are ignored until reset.
- Address arithmetic is modulo 2^ADDR_W. TEST_START+`i` wraps past 14'h3fff to 0.

## Timing
- Reset values: `mem_req`=0, `mem_ceb`=1, `mem_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `halted`=0, `done`=0. State is RUN, cycle counter is 0.
- Reset asserted mid-stream aborts immediately: all outputs return to their reset values and no `done` pulse is produced.
- `halted` rises the cycle after the matching store.
- First `out_valid`: halt edge+1 gives REQ; with grant already high, RD at +2, CAP at +3, `out_valid` at +4.
- Per word with `out_ready` tied high: 3 cycles (RD, CAP, SEND).
- Cycle counter: 64 bits, increments every cycle after reset release, holds the value reached at the halt edge, wraps on overflow.
- `out_valid` never drops without a handshake. `out_data` and `out_last` stay stable while `out_valid && !out_ready`.

## Configuration
- `RESULT_CYCLE_EN` defined: two extra words (cycle count low, then high) follow the results, and `out_last` moves to the high word.
- `RESULT_CYCLE_EN` not defined: CYC_LO/CYC_HI and the counter are not built, and `out_last` is on result word `n-1`.

## Test plan
- Store 32'h1234 to word 'h3fff, then END_CODE to 'h3ffe -> `halted` stays 0. Then END_CODE to 'h3fff -> `halted`=1 the next cycle.
- Preload DM 'h2000..'h2002 = 11,22,33, `cfg_num`=3, `out_ready`=1, grant high -> stream 11,22,33 with `out_last` on 33 (macro off), first `out_valid` 4 cycles after halt, `done` pulse after.
- Same as previous, but with `out_ready` toggling 1-in-3 and `mem_gnt` dropped for 5 cycles mid-stream -> identical data order, `out_data` stable while stalled, no extra SRAM reads.
- `cfg_num`=100 -> exactly 64 words, addresses 'h2000..'h203f.
- With RESULT_CYCLE_EN, halt at cycle 1000 and `cfg_num`=0 -> words 1000 then 0, `out_last` on the second.
- Reset pulsed while in SEND -> outputs return to reset values. A new halt marker then restarts from 'h2000.
